// File: rtl/cos_sim_job_arbiter.sv
// Round-robin job front-end for one cosine-similarity engine; latency: start 1 cycle after grant, response 1 cycle after done.
// Backpressure: one job in flight, req_ready low outside IDLE, response held until the owner's rsp_ready.
module cos_sim_job_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [32*NUM_REQ-1:0]  req_a_vec,
    input  logic [32*NUM_REQ-1:0]  req_b_vec,
    output logic [NUM_REQ-1:0]     rsp_valid,
    input  logic [NUM_REQ-1:0]     rsp_ready,
    output logic [15:0]            rsp_result,
    output logic                   rsp_error,
    output logic                   eng_start,
    output logic [31:0]            eng_a_vec,
    output logic [31:0]            eng_b_vec,
    input  logic                   eng_done,
    input  logic [15:0]            eng_result,
    output logic                   eng_abort,
    output logic                   busy,
    output logic [2:0]             grant_id
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [15:0]        WD_LAST  = 16'(TIMEOUT_CYCLES - 1);
    localparam bit                 WD_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [2:0]         LAST_RST = 3'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE      = 1;

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  last_grant;
    logic [15:0] wd_cnt;
    logic        win_vld;
    logic [2:0]  win_idx;
    logic [31:0] win_a;
    logic [31:0] win_b;
    logic        timeout_hit;
    logic        rsp_hs;

    // Lowest valid index above last_grant wins; otherwise wrap to the lowest valid index.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        win_a   = '0;
        win_b   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && i <= int'(last_grant)) begin
                win_vld = 1'b1;
                win_idx = 3'(i);
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && i > int'(last_grant)) begin
                win_vld = 1'b1;
                win_idx = 3'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == 3'(i)) begin
                win_a = req_a_vec[32*i +: 32];
                win_b = req_b_vec[32*i +: 32];
            end
        end
    end

    assign timeout_hit = WD_EN && (wd_cnt == WD_LAST);
    assign rsp_hs      = |(rsp_valid & rsp_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_vld) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (eng_done || timeout_hit) state_nxt = RESP;
            RESP:    if (rsp_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        eng_start = 1'b0;
        eng_abort = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE:    if (win_vld) req_ready = ONE << win_idx;
            ISSUE:   eng_start = 1'b1;
            // A done arriving on the timeout cycle completes the job, so no abort.
            WAIT:    eng_abort = timeout_hit && !eng_done;
            RESP:    rsp_valid = ONE << grant_id;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= LAST_RST;
            grant_id   <= '0;
            eng_a_vec  <= '0;
            eng_b_vec  <= '0;
            wd_cnt     <= '0;
            rsp_result <= '0;
            rsp_error  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        grant_id  <= win_idx;
                        eng_a_vec <= win_a;
                        eng_b_vec <= win_b;
                    end
                end
                ISSUE: wd_cnt <= '0;
                WAIT: begin
                    wd_cnt <= wd_cnt + 16'd1;
                    if (eng_done) begin
                        rsp_result <= eng_result;
                        rsp_error  <= 1'b0;
                    end else if (timeout_hit) begin
                        rsp_result <= '0;
                        rsp_error  <= 1'b1;
                    end
                end
                RESP: if (rsp_hs) last_grant <= grant_id;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cos_sim_job_arbiter.sv
// Bench for cos_sim_job_arbiter: 3-requester instance for routing/fairness/random, 1-requester instance with an 8-cycle watchdog.
module tb_cos_sim_job_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [2:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [95:0] req_a_vec, req_b_vec;
    logic [15:0] rsp_result, eng_result;
    logic        rsp_error, eng_start, eng_done, eng_abort, busy;
    logic [31:0] eng_a_vec, eng_b_vec;
    logic [2:0]  grant_id;

    logic [0:0]  w_req_valid, w_req_ready, w_rsp_valid, w_rsp_ready;
    logic [31:0] w_req_a_vec, w_req_b_vec, w_eng_a_vec, w_eng_b_vec;
    logic [15:0] w_rsp_result, w_eng_result;
    logic        w_rsp_error, w_eng_start, w_eng_done, w_eng_abort, w_busy;
    logic [2:0]  w_grant_id;

    cos_sim_job_arbiter #(.NUM_REQ(3), .TIMEOUT_CYCLES(1024)) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_a_vec(req_a_vec), .req_b_vec(req_b_vec), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_error(rsp_error),
        .eng_start(eng_start), .eng_a_vec(eng_a_vec), .eng_b_vec(eng_b_vec),
        .eng_done(eng_done), .eng_result(eng_result), .eng_abort(eng_abort),
        .busy(busy), .grant_id(grant_id)
    );

    cos_sim_job_arbiter #(.NUM_REQ(1), .TIMEOUT_CYCLES(8)) u_wd (
        .clk(clk), .reset(reset), .req_valid(w_req_valid), .req_ready(w_req_ready),
        .req_a_vec(w_req_a_vec), .req_b_vec(w_req_b_vec), .rsp_valid(w_rsp_valid),
        .rsp_ready(w_rsp_ready), .rsp_result(w_rsp_result), .rsp_error(w_rsp_error),
        .eng_start(w_eng_start), .eng_a_vec(w_eng_a_vec), .eng_b_vec(w_eng_b_vec),
        .eng_done(w_eng_done), .eng_result(w_eng_result), .eng_abort(w_eng_abort),
        .busy(w_busy), .grant_id(w_grant_id)
    );

    typedef struct {
        logic [2:0]  rv, rr;
        logic        done;
        logic [15:0] res;
        logic [2:0]  e_rdy, e_vld;
        logic        e_start, e_busy;
        logic [2:0]  e_gid;
        logic [15:0] e_res;
        logic [31:0] e_a;
    } vec_t;

    vec_t        tbl[24];
    logic [31:0] a_of[3];
    int          n_vec = 0;
    int          n_bad = 0;

    // Reference model state for the random phase
    bit          pend[3];
    logic [31:0] pa[3], pb[3];
    int          last_m, own, t_hs, t_done, gid_m, win;
    bit          active, in_resp;
    logic [15:0] res_m, job_res;
    logic [31:0] ea, eb;
    logic [2:0]  exp_rdy, exp_vld;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = '0; rsp_ready = '0; eng_done = 1'b0; eng_result = '0;
        w_req_valid = '0; w_rsp_ready = '0; w_eng_done = 1'b0; w_eng_result = '0;
        step();
        reset = 1'b0;
    endtask

    function automatic logic [15:0] rj(input int j);
        return 16'(32'h1000 * (j + 1) + j);
    endfunction

    initial begin
        a_of[0] = 32'h11111111; a_of[1] = 32'h22222222; a_of[2] = 32'h33333333;
        for (int j = 0; j < 6; j++) begin
            int o, po;
            o  = j % 3;
            po = (j == 0) ? 0 : (j - 1) % 3;
            tbl[4*j]   = '{3'b111, 3'b111, 1'b1, 16'hBAD0, 3'b001 << o, 3'b000, 1'b0, 1'b0,
                           3'(po), (j == 0) ? 16'h0 : rj(j - 1), (j == 0) ? 32'h0 : a_of[po]};
            tbl[4*j+1] = '{3'b111, 3'b111, 1'b1, 16'hBAD1, 3'b000, 3'b000, 1'b1, 1'b1,
                           3'(o), (j == 0) ? 16'h0 : rj(j - 1), a_of[o]};
            tbl[4*j+2] = '{3'b111, 3'b111, 1'b1, rj(j), 3'b000, 3'b000, 1'b0, 1'b1,
                           3'(o), (j == 0) ? 16'h0 : rj(j - 1), a_of[o]};
            tbl[4*j+3] = '{3'b111, 3'b111, 1'b1, 16'hBAD3, 3'b000, 3'b001 << o, 1'b0, 1'b1,
                           3'(o), rj(j), a_of[o]};
        end

        reset = 1'b1;
        req_valid = '0; rsp_ready = '0; eng_done = 1'b0; eng_result = '0;
        req_a_vec = {a_of[2], a_of[1], a_of[0]};
        req_b_vec = {32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
        w_req_valid = '0; w_rsp_ready = '0; w_eng_done = 1'b0; w_eng_result = '0;
        w_req_a_vec = 32'hA5A5_0001; w_req_b_vec = 32'h5A5A_0002;
        step();
        do_reset();

        // Reset values
        #1;
        chk("rst_busy", busy, 0); chk("rst_grant_id", grant_id, 0);
        chk("rst_rsp_result", rsp_result, 0); chk("rst_eng_a", eng_a_vec, 0);
        chk("rst_eng_start", eng_start, 0); chk("rst_rsp_error", rsp_error, 0);
        step();

        // Fairness table: stale done in IDLE/ISSUE/RESP is ignored
        for (int k = 0; k < 24; k++) begin
            req_valid = tbl[k].rv; rsp_ready = tbl[k].rr;
            eng_done = tbl[k].done; eng_result = tbl[k].res;
            #1;
            chk("tbl_req_ready", req_ready, tbl[k].e_rdy);
            chk("tbl_rsp_valid", rsp_valid, tbl[k].e_vld);
            chk("tbl_eng_start", eng_start, tbl[k].e_start);
            chk("tbl_busy", busy, tbl[k].e_busy);
            chk("tbl_grant_id", grant_id, tbl[k].e_gid);
            chk("tbl_rsp_result", rsp_result, tbl[k].e_res);
            chk("tbl_eng_a", eng_a_vec, tbl[k].e_a);
            step();
        end

        // Single job, 20-cycle engine
        do_reset();
        req_a_vec[31:0] = 32'h04030201; req_b_vec[31:0] = 32'h08070605;
        req_valid = 3'b001; rsp_ready = 3'b001;
        #1; chk("single_hs", req_ready, 3'b001);
        step();
        req_valid = '0;
        #1; chk("single_start", eng_start, 1); chk("single_eng_a", eng_a_vec, 32'h04030201);
        chk("single_eng_b", eng_b_vec, 32'h08070605);
        step();
        for (int k = 1; k <= 20; k++) begin
            eng_done = (k == 20); eng_result = (k == 20) ? 16'h7E3A : 16'h0;
            #1; chk("single_wait", {eng_start, rsp_valid}, 0);
            step();
        end
        eng_done = 1'b0;
        #1; chk("single_rsp_valid", rsp_valid, 3'b001); chk("single_result", rsp_result, 16'h7E3A);
        chk("single_error", rsp_error, 0);
        step();
        #1; chk("single_idle", busy, 0);

        // Backpressure: last_grant=0, requester 0 again, others waiting
        req_valid = 3'b001; rsp_ready = 3'b000;
        #1; chk("bp_hs", req_ready, 3'b001);
        step();
        req_valid = 3'b110;
        #1; chk("bp_issue_rdy", req_ready, 0);
        step();
        eng_done = 1'b1; eng_result = 16'h1234;
        step();
        eng_done = 1'b0;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("bp_rsp_valid", rsp_valid, 3'b001); chk("bp_result", rsp_result, 16'h1234);
            chk("bp_req_ready", req_ready, 0);
            step();
        end
        rsp_ready = 3'b001;
        #1; chk("bp_release", rsp_valid, 3'b001);
        step();
        rsp_ready = 3'b000;
        #1; chk("bp_next_grant", req_ready, 3'b010);
        step();
        req_valid = '0;
        #1; chk("rw_issue", {eng_start, grant_id}, {1'b1, 3'd1});
        step();

        // Reset while in WAIT
        reset = 1'b1;
        #1; chk("rw_in_wait", busy, 1);
        step();
        reset = 1'b0; eng_done = 1'b1; eng_result = 16'hBEEF;
        #1;
        chk("rw_busy", busy, 0); chk("rw_grant", grant_id, 0); chk("rw_result", rsp_result, 0);
        chk("rw_eng_a", eng_a_vec, 0); chk("rw_outs", {rsp_valid, req_ready, eng_start, eng_abort, rsp_error}, 0);
        step();
        eng_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1; chk("rw_late_done", {rsp_valid, busy}, 0);
            step();
        end
        req_valid = 3'b111;
        #1; chk("rw_first_grant", req_ready, 3'b001);
        step();

        // Watchdog timeout (NUM_REQ=1, TIMEOUT_CYCLES=8)
        do_reset();
        w_req_valid = 1'b1;
        #1; chk("to_hs", w_req_ready, 1);
        step();
        w_req_valid = 1'b0;
        #1; chk("to_start", w_eng_start, 1); chk("to_eng_a", w_eng_a_vec, 32'hA5A5_0001);
        chk("to_eng_b", w_eng_b_vec, 32'h5A5A_0002); chk("to_grant", w_grant_id, 0);
        step();
        for (int k = 2; k <= 9; k++) begin
            #1; chk("to_abort", w_eng_abort, (k == 9)); chk("to_no_rsp", w_rsp_valid, 0);
            step();
        end
        #1; chk("to_rsp_valid", w_rsp_valid, 1); chk("to_error", w_rsp_error, 1);
        chk("to_result", w_rsp_result, 0); chk("to_abort_once", w_eng_abort, 0);
        step();
        w_rsp_ready = 1'b1;
        #1; chk("to_rsp_hold", w_rsp_valid, 1);
        step();
        w_rsp_ready = 1'b0;
        #1; chk("to_idle", w_busy, 0);

        // Done arriving on the timeout cycle wins
        w_req_valid = 1'b1;
        #1; chk("col_hs", w_req_ready, 1);
        step();
        w_req_valid = 1'b0;
        step();
        for (int k = 2; k <= 9; k++) begin
            w_eng_done = (k == 9); w_eng_result = (k == 9) ? 16'h55AA : 16'h0;
            #1; chk("col_no_abort", w_eng_abort, 0);
            step();
        end
        w_eng_done = 1'b0; w_rsp_ready = 1'b1;
        #1; chk("col_rsp_valid", w_rsp_valid, 1); chk("col_error", w_rsp_error, 0);
        chk("col_result", w_rsp_result, 16'h55AA);
        step();

        // Randomized traffic against the transaction-level model
        do_reset();
        w_rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin pend[i] = 0; pa[i] = '0; pb[i] = '0; end
        last_m = 2; active = 0; in_resp = 0; own = 0; t_hs = 0; t_done = 0; gid_m = 0;
        res_m = '0; job_res = '0; ea = '0; eb = '0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i] = 1; pa[i] = $urandom; pb[i] = $urandom;
                end
                req_valid[i] = pend[i];
                req_a_vec[32*i +: 32] = pa[i];
                req_b_vec[32*i +: 32] = pb[i];
            end
            rsp_ready = 3'($urandom);
            if (active && !in_resp && c == t_done) begin
                eng_done = 1'b1; eng_result = job_res;
            end else if (active && !in_resp && c > t_hs + 1) begin
                eng_done = 1'b0; eng_result = 16'($urandom);
            end else begin
                eng_done = 1'($urandom_range(0, 1)); eng_result = 16'($urandom);
            end
            win = -1;
            if (!active) begin
                for (int k = 1; k <= 3; k++) begin
                    if (win < 0 && pend[(last_m + k) % 3]) win = (last_m + k) % 3;
                end
            end
            exp_rdy = (win >= 0) ? (3'b001 << win) : 3'b000;
            exp_vld = in_resp ? (3'b001 << own) : 3'b000;
            #1;
            chk("rnd_req_ready", req_ready, exp_rdy);
            chk("rnd_rsp_valid", rsp_valid, exp_vld);
            chk("rnd_eng_start", eng_start, (active && c == t_hs + 1));
            chk("rnd_busy", busy, active);
            chk("rnd_grant_id", grant_id, 3'(gid_m));
            chk("rnd_result", {rsp_error, eng_abort, rsp_result}, {2'b00, res_m});
            chk("rnd_eng_ab", {eng_a_vec, eng_b_vec}, {ea, eb});
            if (win >= 0) begin
                active = 1; own = win; gid_m = win; t_hs = c;
                t_done = c + 2 + int'($urandom_range(0, 5));
                job_res = 16'($urandom); ea = pa[win]; eb = pb[win]; pend[win] = 0;
            end else if (active && !in_resp && c == t_done) begin
                in_resp = 1; res_m = job_res;
            end else if (in_resp && rsp_ready[own]) begin
                in_resp = 0; active = 0; last_m = own;
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
